glitch_pulse_gen: RTL and testbench

Consumes the single-cycle periodic trigger produced by the glitcher cycle counter and turns it into one programmable glitch pulse. After a one-shot arm, the first accepted trigger starts a delay of DELAY cycles, then glitch_out drives high for WIDTH cycles. The block then reports done and disarms. It sits between the trigger counter and the glitch output driver in glitcher_top.

---
 rtl/glitch_pulse_gen_if.sv | 28 ++
 rtl/glitch_pulse_gen.sv | 117 +++++++++++
 tb/tb_glitch_pulse_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/glitch_pulse_gen_if.sv
// Control, configuration and status signals between a glitch pulse generator
// and its controller.
interface glitch_pulse_gen_if #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int MISS_W  = 8
);
  logic               arm;
  logic               abort;
  logic               trig_in;
  logic [DELAY_W-1:0] delay_cfg;
  logic [WIDTH_W-1:0] width_cfg;
  logic               glitch_out;
  logic               armed;
  logic               busy;
  logic               done;
  logic [MISS_W-1:0]  miss_cnt;

  modport master (
    output arm, abort, trig_in, delay_cfg, width_cfg,
    input  glitch_out, armed, busy, done, miss_cnt
  );

  modport slave (
    input  arm, abort, trig_in, delay_cfg, width_cfg,
    output glitch_out, armed, busy, done, miss_cnt
  );
endinterface

// File: rtl/glitch_pulse_gen.sv
// One-shot glitch pulse generator: after arm, the first trigger starts a
// programmable delay followed by a programmable-width glitch, then done.
module glitch_pulse_gen #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int MISS_W  = 8
) (
  input logic               clk_in1,
  input logic               reset,
  glitch_pulse_gen_if.slave pulse_if
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_DELAY  = 3'd2,
    S_GLITCH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [WIDTH_W-1:0] wlen_q, wlen_d;
  logic [WIDTH_W-1:0] wcnt_q, wcnt_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               glitch_q, armed_q, busy_q, done_q;
  logic               glitch_d, armed_d, busy_d, done_d;
  logic               busy_now_s;

  assign busy_now_s = (state_q == S_DELAY) || (state_q == S_GLITCH);

  // Next-state, counter and output decode; counters hold "cycles remaining minus one".
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wlen_d  = wlen_q;
    wcnt_d  = wcnt_q;
    miss_d  = miss_q;
    if (pulse_if.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pulse_if.arm) state_d = S_ARMED;
          else              state_d = S_IDLE;
        end
        S_ARMED: begin
          if (pulse_if.trig_in) begin
            wlen_d = pulse_if.width_cfg;
            dcnt_d = pulse_if.delay_cfg - DELAY_W'(1);
            wcnt_d = pulse_if.width_cfg - WIDTH_W'(1);
            if (pulse_if.width_cfg == {WIDTH_W{1'b0}})      state_d = S_DONE;
            else if (pulse_if.delay_cfg == {DELAY_W{1'b0}}) state_d = S_GLITCH;
            else                                            state_d = S_DELAY;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_DELAY: begin
          if (dcnt_q == {DELAY_W{1'b0}}) begin
            state_d = S_GLITCH;
            wcnt_d  = wlen_q - WIDTH_W'(1);
          end else begin
            dcnt_d  = dcnt_q - DELAY_W'(1);
          end
        end
        S_GLITCH: begin
          if (wcnt_q == {WIDTH_W{1'b0}}) state_d = S_DONE;
          else                           wcnt_d  = wcnt_q - WIDTH_W'(1);
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (pulse_if.trig_in && busy_now_s && (miss_q != {MISS_W{1'b1}})) begin
        miss_d = miss_q + MISS_W'(1);
      end else begin
        miss_d = miss_q;
      end
    end
    glitch_d = (state_d == S_GLITCH);
    armed_d  = (state_d == S_ARMED);
    busy_d   = (state_d == S_DELAY) || (state_d == S_GLITCH);
    done_d   = (state_d == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dcnt_q   <= {DELAY_W{1'b0}};
      wlen_q   <= {WIDTH_W{1'b0}};
      wcnt_q   <= {WIDTH_W{1'b0}};
      miss_q   <= {MISS_W{1'b0}};
      glitch_q <= 1'b0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      miss_q   <= miss_d;
      glitch_q <= glitch_d;
      armed_q  <= armed_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pulse_if.glitch_out = glitch_q;
  assign pulse_if.armed      = armed_q;
  assign pulse_if.busy       = busy_q;
  assign pulse_if.done       = done_q;
  assign pulse_if.miss_cnt   = miss_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Self-checking bench for glitch_pulse_gen: timeline model of each shot plus
// directed literal checks and randomized stimulus.
module tb_glitch_pulse_gen;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int MW = 8;
  localparam int MISS_MAX = (1 << MW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  glitch_pulse_gen_if #(.DELAY_W(DW), .WIDTH_W(WW), .MISS_W(MW)) bus ();

  glitch_pulse_gen #(.DELAY_W(DW), .WIDTH_W(WW), .MISS_W(MW)) dut (
    .clk_in1  (clk),
    .reset    (rst),
    .pulse_if (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: a shot is a timeline anchored at its accepting edge t0
  longint edge_n = 0;
  bit     m_armed, m_shot;
  longint t0;
  int     md, mw, miss;
  bit     e_g, e_a, e_b, e_d;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    longint j;
    edge_n++;
    if (rst) begin
      m_armed = 0; m_shot = 0; miss = 0;
    end else if (bus.abort) begin
      m_armed = 0; m_shot = 0;
    end else if (m_shot) begin
      j = edge_n - 1 - t0;
      if (bus.trig_in && mw > 0 && j < md + mw)
        miss = (miss < MISS_MAX) ? miss + 1 : MISS_MAX;
      if (edge_n - t0 > md + mw) m_shot = 0;
    end else if (m_armed) begin
      if (bus.trig_in) begin
        m_shot = 1; m_armed = 0; t0 = edge_n;
        mw = int'(bus.width_cfg);
        md = (mw == 0) ? 0 : int'(bus.delay_cfg);
      end
    end else if (bus.arm) begin
      m_armed = 1;
    end
    e_a = m_armed;
    e_g = 0; e_b = 0; e_d = 0;
    if (m_shot) begin
      j = edge_n - t0;
      e_g = (mw > 0) && (j >= md) && (j < md + mw);
      e_b = (mw > 0) && (j < md + mw);
      e_d = (j == md + mw);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("glitch_out", bus.glitch_out, e_g);
    check("armed",      bus.armed,      e_a);
    check("busy",       bus.busy,       e_b);
    check("done",       bus.done,       e_d);
    check("miss_cnt",   bus.miss_cnt,   miss);
  endtask

  task automatic idle_inputs();
    bus.arm = 0; bus.abort = 0; bus.trig_in = 0;
  endtask

  // arm, trigger, then record glitch/done over the 8 cycles after the trigger
  task automatic shot(input int d, input int w, input bit chg,
                      input logic [7:0] eg, input logic [7:0] ed, input string nm);
    logic [7:0] g, dn;
    bus.arm = 1; tick(); bus.arm = 0;
    bus.delay_cfg = DW'(d); bus.width_cfg = WW'(w); bus.trig_in = 1;
    tick(); bus.trig_in = 0;
    g[0] = bus.glitch_out; dn[0] = bus.done;
    for (int k = 1; k < 8; k++) begin
      if (chg && k == 1) bus.delay_cfg = DW'(20);
      tick();
      g[k] = bus.glitch_out; dn[k] = bus.done;
    end
    check({nm, "_glitch_pattern"}, g, eg);
    check({nm, "_done_pattern"}, dn, ed);
    check({nm, "_armed_after"}, bus.armed, 0);
    check({nm, "_busy_after"}, bus.busy, 0);
  endtask

  initial begin
    logic [7:0] seen;
    rst = 1; idle_inputs();
    bus.delay_cfg = '0; bus.width_cfg = '0;
    tick(); tick();
    rst = 0;
    check("reset_glitch", bus.glitch_out, 0);
    check("reset_armed", bus.armed, 0);
    check("reset_done", bus.done, 0);
    check("reset_miss", bus.miss_cnt, 0);
    tick();

    shot(3, 2, 0, 8'b0001_1000, 8'b0010_0000, "d3w2");
    shot(0, 1, 0, 8'b0000_0001, 8'b0000_0010, "d0w1");
    shot(5, 0, 0, 8'b0000_0000, 8'b0000_0001, "d5w0");
    check("w0_miss_unchanged", bus.miss_cnt, 0);
    shot(3, 2, 1, 8'b0001_1000, 8'b0010_0000, "cfg_change");

    // abort in the 2nd glitch cycle, then triggers without re-arm
    bus.arm = 1; tick(); bus.arm = 0;
    bus.delay_cfg = DW'(0); bus.width_cfg = WW'(8); bus.trig_in = 1;
    tick(); bus.trig_in = 0;
    check("abort_pre_glitch1", bus.glitch_out, 1);
    tick();
    check("abort_pre_glitch2", bus.glitch_out, 1);
    bus.abort = 1; tick(); bus.abort = 0;
    check("abort_glitch", bus.glitch_out, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    seen = '0;
    bus.trig_in = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen[k] = bus.glitch_out | bus.busy | bus.done | bus.armed;
    end
    bus.trig_in = 0;
    check("no_rearm_response", seen, 0);
    tick();

    // D=10, W=4, trigger every 3 cycles: 4 misses per shot until saturation
    bus.delay_cfg = DW'(10); bus.width_cfg = WW'(4);
    for (int s = 1; s <= 66; s++) begin
      bus.arm = 1; tick(); bus.arm = 0;
      bus.trig_in = 1; tick();
      for (int k = 1; k <= 16; k++) begin
        bus.trig_in = (k % 3 == 0);
        tick();
        if (k == 14) begin
          check("miss_done_pulse", bus.done, 1);
          check("miss_at_done", bus.miss_cnt, (4 * s > 255) ? 255 : 4 * s);
        end
      end
      bus.trig_in = 0;
    end
    check("miss_saturated", bus.miss_cnt, 255);

    // reset during GLITCH
    bus.arm = 1; tick(); bus.arm = 0;
    bus.delay_cfg = DW'(0); bus.width_cfg = WW'(8); bus.trig_in = 1;
    tick(); bus.trig_in = 0;
    tick();
    check("pre_reset_glitch", bus.glitch_out, 1);
    rst = 1; tick(); rst = 0;
    check("reset_mid_glitch", bus.glitch_out, 0);
    check("reset_mid_busy", bus.busy, 0);
    check("reset_mid_miss", bus.miss_cnt, 0);
    tick();

    // maximum width
    bus.arm = 1; tick(); bus.arm = 0;
    bus.delay_cfg = DW'(1); bus.width_cfg = WW'(255); bus.trig_in = 1;
    tick(); bus.trig_in = 0;
    for (int k = 0; k < 260; k++) tick();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bus.arm     = ($urandom_range(0, 3) == 0);
      bus.trig_in = ($urandom_range(0, 3) == 0);
      bus.abort   = ($urandom_range(0, 63) == 0);
      rst         = ($urandom_range(0, 255) == 0);
      if ($urandom_range(0, 7) == 0) begin
        bus.delay_cfg = DW'($urandom_range(0, 12));
        bus.width_cfg = WW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 255)
                                                        : $urandom_range(0, 6));
      end
      tick();
    end
    rst = 0; idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
